// File: rtl/music_pkg.sv
// Shared types and constants for the note sequencer and its frequency converter.
package music_pkg;

    localparam int unsigned NOTE_W  = 7;
    localparam int unsigned FREQ_W  = 24;
    localparam int unsigned ENTRY_W = 9;
    localparam int unsigned OCT_W   = 4;

    // One pattern slot: tie continues a held note legato, rest silences the step.
    typedef struct packed {
        logic              tie;
        logic              rest;
        logic [NOTE_W-1:0] note;
    } pattern_entry_t;

    // round(f*256) for MIDI 120..131 (C9..B9); lower octaves are right shifts of these.
    localparam logic [FREQ_W-1:0] NOTE_TABLE [12] = '{
        24'd2143237, 24'd2270680, 24'd2405702, 24'd2548752,
        24'd2700309, 24'd2860878, 24'd3030994, 24'd3211227,
        24'd3402176, 24'd3604480, 24'd3818814, 24'd4045892
    };

    localparam pattern_entry_t    REST_ENTRY = '{tie: 1'b0, rest: 1'b1, note: 7'd0};
    localparam logic [FREQ_W-1:0] A4_FREQ    = 24'd112640;

    typedef enum logic [1:0] {
        SEQ_IDLE    = 2'd0,
        SEQ_UPDATE  = 2'd1,
        SEQ_CONVERT = 2'd2,
        SEQ_FINISH  = 2'd3
    } seq_state_t;

    typedef enum logic {
        N2F_IDLE   = 1'b0,
        N2F_DIVIDE = 1'b1
    } n2f_state_t;

endpackage

// File: rtl/step_sequencer_note_to_freq.sv
// note_to_freq: MIDI note number to Hz*256 frequency.
// Splits the note into octave/semitone by subtracting 12 once per cycle, then
// shifts the top-octave table entry down by (10 - octave).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start_i    one-cycle request, accepted only when idle
//   note_i     7-bit MIDI note, sampled with start_i
//   finish_o   one-cycle done pulse, floor(note/12)+2 cycles after start_i
//   freq_o     result, valid from finish_o until the next result
module note_to_freq
    import music_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [NOTE_W-1:0] note_i,
    output logic              finish_o,
    output logic [FREQ_W-1:0] freq_o
);

    n2f_state_t        state_q, state_d;
    logic [NOTE_W-1:0] rem_q, rem_d;
    logic [OCT_W-1:0]  oct_q, oct_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic              finish_q, finish_d;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= N2F_IDLE;
            rem_q    <= '0;
            oct_q    <= '0;
            freq_q   <= '0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            oct_q    <= oct_d;
            freq_q   <= freq_d;
            finish_q <= finish_d;
        end
    end

    // Divide loop: one subtraction per cycle, the final compare cycle produces the result.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        oct_d    = oct_q;
        freq_d   = freq_q;
        finish_d = 1'b0;
        case (state_q)
            N2F_IDLE: begin
                if (start_i) begin
                    rem_d   = note_i;
                    oct_d   = '0;
                    state_d = N2F_DIVIDE;
                end
            end
            N2F_DIVIDE: begin
                if (rem_q >= NOTE_W'(12)) begin
                    rem_d = rem_q - NOTE_W'(12);
                    oct_d = oct_q + OCT_W'(1);
                end else begin
                    freq_d   = NOTE_TABLE[rem_q[3:0]] >> (OCT_W'(10) - oct_q);
                    finish_d = 1'b1;
                    state_d  = N2F_IDLE;
                end
            end
            default: state_d = N2F_IDLE;
        endcase
    end

    assign finish_o = finish_q;
    assign freq_o   = freq_q;

endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: per-sample-frame note source for one instrument voice.
// Walks a writable pattern at a fixed step length, producing gate, a one-frame
// trigger on each new (non-tied) note, and the note frequency in Hz*256.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      one-cycle frame strobe (ignored unless idle)
//   finish     one-cycle done pulse
//   run        transport enable, sampled in the frame's update cycle
//   pat_we     pattern write enable; pat_addr / pat_data = {tie, rest, note}
//   gate       note held
//   trigger    new-note strobe, high for one frame
//   freq       note frequency, Hz*256
//   step       current step index
module step_sequencer
    import music_pkg::*;
#(
    parameter int unsigned STEPS            = 16,
    parameter int unsigned SAMPLES_PER_STEP = 6000,
    parameter int unsigned GATE_SAMPLES     = 4500
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     finish,
    input  logic                     run,
    input  logic                     pat_we,
    input  logic [$clog2(STEPS)-1:0] pat_addr,
    input  logic [ENTRY_W-1:0]       pat_data,
    output logic                     gate,
    output logic                     trigger,
    output logic [FREQ_W-1:0]        freq,
    output logic [$clog2(STEPS)-1:0] step
);

    localparam int unsigned STEP_W = $clog2(STEPS);
    localparam int unsigned CNT_W  = $clog2(SAMPLES_PER_STEP);

    pattern_entry_t    pattern_q [STEPS];

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              gate_q, gate_d;
    logic              trig_q, trig_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic              finish_q, finish_d;
    logic              trig_pend_q, trig_pend_d;
    logic [NOTE_W-1:0] conv_note_q, conv_note_d;
    logic              conv_start_q, conv_start_d;

    pattern_entry_t    cur_entry_c;
    logic [STEP_W-1:0] next_idx_c;
    logic              next_tied_c;
    logic [CNT_W-1:0]  cnt_adv_c;
    logic [STEP_W-1:0] step_adv_c;

    logic              n2f_finish;
    logic [FREQ_W-1:0] n2f_freq;

    // Pattern storage: writable in any state, cleared to rests on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(STEPS); i++) begin
                pattern_q[i] <= REST_ENTRY;
            end
        end else if (pat_we) begin
            pattern_q[pat_addr] <= pat_data;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SEQ_IDLE;
            cnt_q        <= '0;
            step_q       <= '0;
            gate_q       <= 1'b0;
            trig_q       <= 1'b0;
            freq_q       <= A4_FREQ;
            finish_q     <= 1'b0;
            trig_pend_q  <= 1'b0;
            conv_note_q  <= '0;
            conv_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            gate_q       <= gate_d;
            trig_q       <= trig_d;
            freq_q       <= freq_d;
            finish_q     <= finish_d;
            trig_pend_q  <= trig_pend_d;
            conv_note_q  <= conv_note_d;
            conv_start_q <= conv_start_d;
        end
    end

    // Pattern lookups and the per-frame counter advance (step index wraps by width).
    always_comb begin
        cur_entry_c = pattern_q[step_q];
        next_idx_c  = step_q + STEP_W'(1);
        next_tied_c = pattern_q[next_idx_c].tie && !pattern_q[next_idx_c].rest;
        if (cnt_q == CNT_W'(SAMPLES_PER_STEP - 1)) begin
            cnt_adv_c  = '0;
            step_adv_c = step_q + STEP_W'(1);
        end else begin
            cnt_adv_c  = cnt_q + CNT_W'(1);
            step_adv_c = step_q;
        end
    end

    // Frame FSM. Visible outputs and counters only move on the edge entering FINISH,
    // so cnt_q/step_q stay put while a conversion is in flight.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        step_d       = step_q;
        gate_d       = gate_q;
        trig_d       = trig_q;
        freq_d       = freq_q;
        finish_d     = 1'b0;
        trig_pend_d  = trig_pend_q;
        conv_note_d  = conv_note_q;
        conv_start_d = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    state_d = SEQ_UPDATE;
                end
            end
            SEQ_UPDATE: begin
                if (!run) begin
                    gate_d   = 1'b0;
                    trig_d   = 1'b0;
                    step_d   = '0;
                    cnt_d    = '0;
                    finish_d = 1'b1;
                    state_d  = SEQ_FINISH;
                end else if (cnt_q == '0) begin
                    if (cur_entry_c.rest) begin
                        gate_d   = 1'b0;
                        trig_d   = 1'b0;
                        cnt_d    = cnt_adv_c;
                        step_d   = step_adv_c;
                        finish_d = 1'b1;
                        state_d  = SEQ_FINISH;
                    end else begin
                        // Tie only suppresses the retrigger if the previous note is still held.
                        trig_pend_d  = !(cur_entry_c.tie && gate_q);
                        conv_note_d  = cur_entry_c.note;
                        conv_start_d = 1'b1;
                        state_d      = SEQ_CONVERT;
                    end
                end else begin
                    trig_d = 1'b0;
                    // Gate falls at the gate length unless the next step ties into this note.
                    if ((cnt_q == CNT_W'(GATE_SAMPLES)) && !next_tied_c) begin
                        gate_d = 1'b0;
                    end
                    cnt_d    = cnt_adv_c;
                    step_d   = step_adv_c;
                    finish_d = 1'b1;
                    state_d  = SEQ_FINISH;
                end
            end
            SEQ_CONVERT: begin
                if (n2f_finish) begin
                    gate_d   = 1'b1;
                    trig_d   = trig_pend_q;
                    freq_d   = n2f_freq;
                    cnt_d    = cnt_adv_c;
                    step_d   = step_adv_c;
                    finish_d = 1'b1;
                    state_d  = SEQ_FINISH;
                end
            end
            SEQ_FINISH: begin
                state_d = SEQ_IDLE;
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    note_to_freq u_note_to_freq (
        .clk      (clk),
        .rst      (rst),
        .start_i  (conv_start_q),
        .note_i   (conv_note_q),
        .finish_o (n2f_finish),
        .freq_o   (n2f_freq)
    );

    assign finish  = finish_q;
    assign gate    = gate_q;
    assign trigger = trig_q;
    assign freq    = freq_q;
    assign step    = step_q;

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
- Per-sample note source feeding one instrument voice's gate, trigger and freq inputs. Runs once per sample frame under the frame controller's start/finish chain, immediately before the voice it drives.
- Steps through a writable pattern of MIDI notes at a fixed step length in samples.
- Converts note numbers to Hz*256 (unsigned -8) frequency.

Parameters:
- STEPS, 16: pattern length in steps; power of two.
- SAMPLES_PER_STEP, 6000: samples per step (16ths at 120 BPM, 48 kHz).
- GATE_SAMPLES, 4500: gate-high samples per non-tied note; must be < SAMPLES_PER_STEP.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle frame strobe
- finish  out  1  one-cycle done pulse
- run  in  1  transport enable, sampled at start
- pat_we  in  1  pattern write enable
- pat_addr  in  $clog2(STEPS)  pattern write address
- pat_data  in  9  {tie, rest, note[6:0]}
- gate  out  1  note held
- trigger  out  1  new-note strobe, high for exactly one frame
- freq  out  24  note frequency, Hz*256
- step  out  $clog2(STEPS)  current step index

Behaviour:
- Reset and clock: rst synchronous, active-high; clock clk.
- Reset values: gate=0, trigger=0, freq=112640 (440 Hz), finish=0, step=0, sample counter=0. All pattern entries reset to rest (9'h080).
- pat_we writes entry at pat_addr on the clock edge, in any state. The entry for the current frame is latched in UPDATE, so later writes affect the next fetch only.
- gate, trigger, freq and step change only on the cycle entering FINISH. They are stable from IDLE until the next start.
- States: IDLE, UPDATE, CONVERT, FINISH.
- IDLE: on start, go to UPDATE.
- UPDATE, run=0: next gate=0, trigger=0, step=0, cnt=0; go to FINISH. Next run frame therefore begins step 0 with a fetch.
- UPDATE, run=1, cnt==0 (step boundary): latch entry[step].
  - rest=1: gate=0, trigger=0, freq held; go to FINISH.
  - tie=1 and current gate=1: gate=1, trigger=0, new freq (legato); go to CONVERT.
  - otherwise: gate=1, trigger=1, new freq; go to CONVERT.
- UPDATE, run=1, cnt!=0: trigger=0. At cnt==GATE_SAMPLES, gate=0 unless entry[(step+1) mod STEPS] has tie=1 and rest=0. Go to FINISH.
- Counter (run=1): cnt increments per frame. At SAMPLES_PER_STEP-1 it wraps to 0 and step increments mod STEPS; wrap from STEPS-1 to 0 is seamless.
- CONVERT: starts note_to_freq and waits for its finish, then FINISH.
- FINISH: finish=1 for one cycle, then IDLE.
- start while not IDLE is ignored.
- Reset mid-operation aborts to IDLE with reset values. No finish is emitted.
- Latency, start to finish:
  - no conversion: 2 cycles;
  - conversion: floor(n/12)+5 cycles.
- note_to_freq (n = 7-bit note):
  - Division by repeated subtraction of 12: quotient oct 0..10, remainder sem 0..11. One subtraction per cycle; the terminating compare takes one cycle.
  - freq = NOTE_TABLE[sem] >> (10-oct), truncating.
  - NOTE_TABLE holds round(f*256) for MIDI 120..131 (C9=2143237 … A9=3604480 … B9=4045892).
  - All values fit in 24 bits unsigned. No rounding after the shift.
  - finish is asserted floor(n/12)+2 cycles after its start.

Decomposition:
- music_pkg holds:
  - typedef struct packed pattern_entry_t {tie, rest, note[6:0]};
  - NOTE_TABLE[12] constant;
  - REST_ENTRY constant;
  - A4_FREQ=112640.
- One sub-module, note_to_freq: start/finish, note in, freq out, owns the divide loop and table.
- step_sequencer owns the pattern array, counters and FSM.

Test Plan:
- Bench parameters: STEPS=4, SAMPLES_PER_STEP=8, GATE_SAMPLES=6.
- Reset, then one start with run=0 -> finish 2 cycles later; gate=0, trigger=0, freq=112640, step=0.
- Pattern {69,60,0,127}, run=1, 32 frames:
  - trigger on frames 0, 8, 16, 24 only;
  - freq 112640, 66976, 2093, 3211227;
  - gate high frames 0-5 of each step, low frames 6-7;
  - step wraps 3->0 at frame 32.
- Entry1 = {tie=1, note 72}:
  - gate stays high across frames 6-8;
  - no trigger at frame 8;
  - freq changes to 133952 at frame 8.
- Entry2 = rest -> gate=0 and trigger=0 for frames 16-23; freq holds the previous value.
- Note 127 start -> finish exactly 15 cycles after start. Note 0 -> 5 cycles.
- Assert rst during CONVERT -> no finish; outputs return to reset values. Next run frame triggers step 0.
